// File: rtl/arb_pkg.sv
// Shared definitions for the unified-memory arbiter: FSM states, grant ids and
// the default watchdog limit.
package arb_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    GRANT_I = 2'd1,
    GRANT_D = 2'd2
  } state_t;

  localparam logic GNT_I = 1'b0;
  localparam logic GNT_D = 1'b1;

  localparam int TIMEOUT_CYCLES_DEFAULT = 64;

endpackage

// File: rtl/arb_timeout_ctr.sv
// Grant watchdog: counts cycles spent in a grant and flags the cycle in which
// the limit is reached. Used by mem_arbiter only when MEM_ARBITER_TIMEOUT_EN is set.
module arb_timeout_ctr
  import arb_pkg::*;
#(
  parameter int LIMIT = TIMEOUT_CYCLES_DEFAULT
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  logic [9:0] count;

  // count holds the number of grant cycles already completed, so the
  // LIMIT-th grant cycle is the one that sees count == LIMIT-1
  assign expired = enable && (count == 10'(LIMIT - 1));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (enable && !expired) begin
      count <= count + 10'd1;
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Two-requester (fetch/data) arbiter onto a single-port memory with alternating
// tie priority. Define MEM_ARBITER_TIMEOUT_EN to enable the grant watchdog.
module mem_arbiter
  import arb_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEFAULT
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        i_req,
  input  logic [31:0] i_addr,
  output logic [31:0] i_rdata,
  output logic        i_ack,
  output logic        i_err,
  input  logic        d_req,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  input  logic [3:0]  d_byteen,
  output logic [31:0] d_rdata,
  output logic        d_ack,
  output logic        d_err,
  output logic        mem_req,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_byteen,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ack
);

  state_t state;
  logic   last_gnt;
  logic   i_pend;
  logic   d_pend;
  logic   pick_d;
  logic   expired;

  if (TIMEOUT_CYCLES < 2 || TIMEOUT_CYCLES > 1023) begin : g_bad_timeout
    $error("TIMEOUT_CYCLES must be within 2..1023");
  end

  // A request seen in its own ack cycle is the one just served, not a new one
  assign i_pend = i_req && !i_ack;
  assign d_pend = d_req && !d_ack;
  assign pick_d = d_pend && (!i_pend || (last_gnt == GNT_I));

`ifdef MEM_ARBITER_TIMEOUT_EN
  arb_timeout_ctr #(
    .LIMIT (TIMEOUT_CYCLES)
  ) u_timeout (
    .clk     (clk),
    .reset   (reset),
    .clear   (state == IDLE),
    .enable  (state != IDLE),
    .expired (expired)
  );
`else
  assign expired = 1'b0;
  assign i_err   = 1'b0;
  assign d_err   = 1'b0;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      last_gnt   <= GNT_I;
      mem_req    <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      mem_byteen <= '0;
      i_rdata    <= '0;
      d_rdata    <= '0;
      i_ack      <= 1'b0;
      d_ack      <= 1'b0;
`ifdef MEM_ARBITER_TIMEOUT_EN
      i_err      <= 1'b0;
      d_err      <= 1'b0;
`endif
    end else begin
      i_ack <= 1'b0;
      d_ack <= 1'b0;
`ifdef MEM_ARBITER_TIMEOUT_EN
      i_err <= 1'b0;
      d_err <= 1'b0;
`endif
      case (state)
        IDLE: begin
          if (pick_d) begin
            state      <= GRANT_D;
            last_gnt   <= GNT_D;
            mem_req    <= 1'b1;
            mem_addr   <= d_addr;
            mem_wdata  <= d_wdata;
            mem_byteen <= d_byteen;
          end else if (i_pend) begin
            state      <= GRANT_I;
            last_gnt   <= GNT_I;
            mem_req    <= 1'b1;
            mem_addr   <= i_addr;
            mem_wdata  <= '0;
            mem_byteen <= '0;
          end
        end
        // mem_ack takes precedence over an expiry in the same cycle
        GRANT_I: begin
          if (mem_ack || expired) begin
            state   <= IDLE;
            mem_req <= 1'b0;
            i_ack   <= 1'b1;
            i_rdata <= mem_ack ? mem_rdata : '0;
`ifdef MEM_ARBITER_TIMEOUT_EN
            i_err   <= !mem_ack;
`endif
          end
        end
        GRANT_D: begin
          if (mem_ack || expired) begin
            state   <= IDLE;
            mem_req <= 1'b0;
            d_ack   <= 1'b1;
            d_rdata <= mem_ack ? mem_rdata : '0;
`ifdef MEM_ARBITER_TIMEOUT_EN
            d_err   <= !mem_ack;
`endif
          end
        end
        default: begin
          state   <= IDLE;
          mem_req <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed scoreboard bench for mem_arbiter; a memory responder and the ack
// monitor run inside one negedge tick task driven by a single initial block.
module tb_mem_arbiter;
  import arb_pkg::*;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  byteen;
    logic [31:0] rdata;
    int          lat;
  } mem_exp_t;

  typedef struct {
    logic        side;
    logic [31:0] rdata;
    logic        err;
  } ack_exp_t;

  logic        clk = 1'b0;
  logic        reset;
  logic        i_req;
  logic [31:0] i_addr;
  logic [31:0] i_rdata;
  logic        i_ack;
  logic        i_err;
  logic        d_req;
  logic [31:0] d_addr;
  logic [31:0] d_wdata;
  logic [3:0]  d_byteen;
  logic [31:0] d_rdata;
  logic        d_ack;
  logic        d_err;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_byteen;
  logic [31:0] mem_rdata;
  logic        mem_ack;

  mem_arbiter #(.TIMEOUT_CYCLES(4)) dut (
    .clk        (clk),
    .reset      (reset),
    .i_req      (i_req),
    .i_addr     (i_addr),
    .i_rdata    (i_rdata),
    .i_ack      (i_ack),
    .i_err      (i_err),
    .d_req      (d_req),
    .d_addr     (d_addr),
    .d_wdata    (d_wdata),
    .d_byteen   (d_byteen),
    .d_rdata    (d_rdata),
    .d_ack      (d_ack),
    .d_err      (d_err),
    .mem_req    (mem_req),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_byteen (mem_byteen),
    .mem_rdata  (mem_rdata),
    .mem_ack    (mem_ack)
  );

  always #5 clk = ~clk;

  int          n_cmp = 0;
  int          n_mis = 0;
  mem_exp_t    mem_q[$];
  ack_exp_t    ack_q[$];
  logic        active = 1'b0;
  int          cur_lat = 0;
  logic [31:0] cur_rd = '0;
  int          grant_cycles = 0;
  int          gap_run = 0;
  int          last_gap = 0;
  int          abandon_len = 0;
  int          done_len = 0;
  int          acks_seen = 0;
  logic        i_rel = 1'b0;
  logic        d_rel = 1'b0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_mis++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic see_ack(input logic side, input logic [31:0] rdata, input logic err);
    ack_exp_t e;
    check("ack_expected", 32'(ack_q.size() > 0), 32'(1));
    if (ack_q.size() > 0) begin
      e = ack_q.pop_front();
      check("ack_side", 32'(side), 32'(e.side));
      check("ack_rdata", rdata, e.rdata);
      check("ack_err", 32'(err), 32'(e.err));
    end
  endtask

  task automatic tick();
    mem_exp_t m;
    @(negedge clk);
    // requesters hold req through their ack cycle and drop it one cycle later
    if (i_rel) begin i_req = 1'b0; i_rel = 1'b0; end
    if (d_rel) begin d_req = 1'b0; d_rel = 1'b0; end
    mem_ack = 1'b0;
    if (mem_req) begin
      if (!active) begin
        active = 1'b1;
        grant_cycles = 0;
        last_gap = gap_run;
        check("mem_req_expected", 32'(mem_q.size() > 0), 32'(1));
        if (mem_q.size() > 0) begin
          m = mem_q.pop_front();
          check("mem_addr", mem_addr, m.addr);
          check("mem_wdata", mem_wdata, m.wdata);
          check("mem_byteen", 32'(mem_byteen), 32'(m.byteen));
          cur_lat = m.lat;
          cur_rd = m.rdata;
        end else begin
          cur_lat = 0;
          cur_rd = '0;
        end
      end
      gap_run = 0;
      grant_cycles++;
      if (cur_lat == 0) begin
        mem_ack = 1'b1;
        mem_rdata = cur_rd;
        active = 1'b0;
        done_len = grant_cycles;
      end else if (cur_lat > 0) begin
        cur_lat--;
      end
    end else begin
      gap_run++;
      if (active) begin
        abandon_len = grant_cycles;
        active = 1'b0;
      end
    end
    if (i_ack) begin see_ack(GNT_I, i_rdata, i_err); i_rel = 1'b1; acks_seen++; end
    if (d_ack) begin see_ack(GNT_D, d_rdata, d_err); d_rel = 1'b1; acks_seen++; end
  endtask

  task automatic wait_acks(input int n, input int budget);
    int start;
    int cyc;
    start = acks_seen;
    cyc = 0;
    while ((acks_seen - start) < n && cyc < budget) begin
      tick();
      cyc++;
    end
    check("ack_count", 32'(acks_seen - start), 32'(n));
    tick();
    check("idle_after_ack", 32'(mem_req), 32'(0));
  endtask

  task automatic push_mem(input logic [31:0] a, input logic [31:0] w, input logic [3:0] b,
                          input logic [31:0] r, input int lat);
    mem_exp_t m;
    m.addr = a; m.wdata = w; m.byteen = b; m.rdata = r; m.lat = lat;
    mem_q.push_back(m);
  endtask

  task automatic push_ack(input logic side, input logic [31:0] r, input logic err);
    ack_exp_t e;
    e.side = side; e.rdata = r; e.err = err;
    ack_q.push_back(e);
  endtask

  task automatic pulse_reset();
    reset = 1'b1;
    tick();
    reset = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

  initial begin
    reset = 1'b1;
    i_req = 1'b0; i_addr = '0;
    d_req = 1'b0; d_addr = '0; d_wdata = '0; d_byteen = '0;
    mem_rdata = '0; mem_ack = 1'b0;
    #1;
    check("rst_mem_req", 32'(mem_req), 32'(0));
    check("rst_mem_addr", mem_addr, 32'h0);
    check("rst_mem_wdata", mem_wdata, 32'h0);
    check("rst_mem_byteen", 32'(mem_byteen), 32'(0));
    check("rst_i_ack", 32'(i_ack), 32'(0));
    check("rst_d_ack", 32'(d_ack), 32'(0));
    check("rst_i_err", 32'(i_err), 32'(0));
    check("rst_d_err", 32'(d_err), 32'(0));
    check("rst_i_rdata", i_rdata, 32'h0);
    check("rst_d_rdata", d_rdata, 32'h0);
    tick();
    reset = 1'b0;

    // single fetch, memory answers in the third grant cycle
    i_addr = 32'h0000_3000; i_req = 1'b1;
    push_mem(32'h0000_3000, 32'h0, 4'h0, 32'h2408_0001, 2);
    push_ack(GNT_I, 32'h2408_0001, 1'b0);
    wait_acks(1, 20);
    check("fetch_i_rdata", i_rdata, 32'h2408_0001);

    // tie straight after reset: D first, then I after one idle cycle
    pulse_reset();
    i_addr = 32'h0000_3004; i_req = 1'b1;
    d_addr = 32'h0000_0010; d_wdata = 32'hA5A5_A5A5; d_byteen = 4'hF; d_req = 1'b1;
    push_mem(32'h0000_0010, 32'hA5A5_A5A5, 4'hF, 32'h1111_1111, 1);
    push_mem(32'h0000_3004, 32'h0, 4'h0, 32'h2222_2222, 0);
    push_ack(GNT_D, 32'h1111_1111, 1'b0);
    push_ack(GNT_I, 32'h2222_2222, 1'b0);
    wait_acks(2, 30);
    check("tie_gap", 32'(last_gap), 32'(1));
    check("write_d_rdata", d_rdata, 32'h1111_1111);

    // lone data read leaves last grant on D
    d_addr = 32'h0000_0020; d_wdata = 32'h0BAD_F00D; d_byteen = 4'h0; d_req = 1'b1;
    push_mem(32'h0000_0020, 32'h0BAD_F00D, 4'h0, 32'h3333_3333, 0);
    push_ack(GNT_D, 32'h3333_3333, 1'b0);
    wait_acks(1, 20);
    check("hold_i_rdata", i_rdata, 32'h2222_2222);

    // second tie now alternates to I first
    i_addr = 32'h0000_3008; i_req = 1'b1;
    d_addr = 32'h0000_0024; d_wdata = 32'h1234_5678; d_byteen = 4'h3; d_req = 1'b1;
    push_mem(32'h0000_3008, 32'h0, 4'h0, 32'h4444_4444, 1);
    push_mem(32'h0000_0024, 32'h1234_5678, 4'h3, 32'h5555_5555, 0);
    push_ack(GNT_I, 32'h4444_4444, 1'b0);
    push_ack(GNT_D, 32'h5555_5555, 1'b0);
    wait_acks(2, 30);

    // stray mem_ack while idle must be ignored
    mem_ack = 1'b1; mem_rdata = 32'hDEAD_BEEF;
    tick();
    tick();
    check("stray_ack_mem_req", 32'(mem_req), 32'(0));
    check("stray_ack_i_rdata", i_rdata, 32'h4444_4444);
    check("stray_ack_d_rdata", d_rdata, 32'h5555_5555);

    // reset in the middle of a data grant
    d_addr = 32'h0000_0040; d_wdata = 32'h0; d_byteen = 4'h0; d_req = 1'b1;
    push_mem(32'h0000_0040, 32'h0, 4'h0, 32'h0, -1);
    tick();
    tick();
    check("pre_reset_mem_req", 32'(mem_req), 32'(1));
    #2 reset = 1'b1;
    #1;
    check("async_mem_req", 32'(mem_req), 32'(0));
    check("async_mem_addr", mem_addr, 32'h0);
    check("async_d_rdata", d_rdata, 32'h0);
    check("async_d_ack", 32'(d_ack), 32'(0));
    d_req = 1'b0;
    i_addr = 32'h0000_300C; i_req = 1'b1;
    push_mem(32'h0000_300C, 32'h0, 4'h0, 32'h6666_6666, 0);
    push_ack(GNT_I, 32'h6666_6666, 1'b0);
    tick();
    reset = 1'b0;
    wait_acks(1, 20);

`ifdef MEM_ARBITER_TIMEOUT_EN
    // memory never answers: watchdog aborts after four grant cycles
    d_addr = 32'h0000_0050; d_wdata = 32'h0; d_byteen = 4'h0; d_req = 1'b1;
    push_mem(32'h0000_0050, 32'h0, 4'h0, 32'h0, -1);
    push_ack(GNT_D, 32'h0, 1'b1);
    wait_acks(1, 30);
    check("timeout_len", 32'(abandon_len), 32'(4));

    // mem_ack arriving in the limit cycle wins
    d_addr = 32'h0000_0054; d_req = 1'b1;
    push_mem(32'h0000_0054, 32'h0, 4'h0, 32'h0000_0055, 3);
    push_ack(GNT_D, 32'h0000_0055, 1'b0);
    wait_acks(1, 30);
    check("race_len", 32'(done_len), 32'(4));
`endif

    check("mem_q_drained", 32'(mem_q.size()), 32'(0));
    check("ack_q_drained", 32'(ack_q.size()), 32'(0));
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
